// File: rtl/bsg_dmc_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// bsg_dmc_cmd_sequencer
//
// Produces the 26-bit DDR-style command stream consumed by the command FIFO
// of the DDR-to-AXI bridge. Simple read/write requests from num_req_p
// clients are arbitrated round-robin. A Load-Mode-Register (LMR) command is
// issued after reset and again on every mode update. An ACTIVATE is inserted
// whenever the target bank/row differs from the single tracked open row.
// Each RD/WR is tagged with the id of the client that owns it.
//
// Ports
//   clk_i            clock
//   reset_n_i        asynchronous active-low reset
//   req_v_i          per-client request valid
//   req_we_i         per-client write enable (1=write, 0=read)
//   req_addr_i       per-client {bank[1:0], row, col[10:0]}, client 0 in LSBs
//   req_ready_o      one-hot; the flagged client's request is captured now
//   cfg_v_i          request an LMR with a new mode
//   cfg_burst_len_i  new burst-length code
//   cfg_cas_i        new CAS-latency code
//   cfg_ready_o      mode update captured this cycle
//   cmd_v_o          command valid (registered)
//   cmd_data_o       {bank[2:0], addr[15:0], cke, cs_n, ras_n, cas_n, we_n,
//                     reset_n, odt} (registered)
//   cmd_ready_i      command FIFO ready
//   cmd_req_id_o     owner of the current RD/WR command
//   init_done_o      first LMR has been accepted
// ---------------------------------------------------------------------------
module bsg_dmc_cmd_sequencer #(
  parameter int         num_req_p        = 2,
  parameter int         row_width_p      = 14,
  parameter logic [2:0] burst_len_code_p = 3'b011,
  parameter logic [2:0] cas_code_p       = 3'b011,
  localparam int bank_width_lp = 2,
  localparam int col_width_lp  = 11,
  localparam int addr_width_lp = bank_width_lp + row_width_p + col_width_lp,
  localparam int id_width_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic [num_req_p-1:0]               req_v_i,
  input  logic [num_req_p-1:0]               req_we_i,
  input  logic [num_req_p*addr_width_lp-1:0] req_addr_i,
  output logic [num_req_p-1:0]               req_ready_o,
  input  logic                               cfg_v_i,
  input  logic [2:0]                         cfg_burst_len_i,
  input  logic [2:0]                         cfg_cas_i,
  output logic                               cfg_ready_o,
  output logic                               cmd_v_o,
  output logic [25:0]                        cmd_data_o,
  input  logic                               cmd_ready_i,
  output logic [id_width_lp-1:0]             cmd_req_id_o,
  output logic                               init_done_o
);

  typedef enum logic [1:0] {
    S_LMR  = 2'd0,
    S_IDLE = 2'd1,
    S_ACT  = 2'd2,
    S_RW   = 2'd3
  } state_e;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] enc_lmr_lp = 4'b0000;
  localparam logic [3:0] enc_act_lp = 4'b0011;
  localparam logic [3:0] enc_rd_lp  = 4'b0101;
  localparam logic [3:0] enc_wr_lp  = 4'b0100;
  localparam logic [3:0] enc_nop_lp = 4'b0111;

  // Assemble the full command word that state st will present on the bus.
  function automatic logic [25:0] build_cmd(
    input state_e                   st,
    input logic                     we,
    input logic [addr_width_lp-1:0] a,
    input logic [2:0]               bl,
    input logic [2:0]               cas
  );
    logic [2:0]              bk;
    logic [15:0]             ad;
    logic [3:0]              enc;
    logic [col_width_lp-1:0] col;
    bk  = '0;
    ad  = '0;
    enc = enc_nop_lp;
    col = a[col_width_lp-1:0];
    case (st)
      S_LMR: begin
        ad[2:0] = bl;      // burst length; addr[3]=0 selects sequential burst
        ad[6:4] = cas;
        enc     = enc_lmr_lp;
      end
      S_ACT: begin
        bk                   = {1'b0, a[addr_width_lp-1 -: bank_width_lp]};
        ad[row_width_p-1:0]  = a[col_width_lp +: row_width_p];
        enc                  = enc_act_lp;
      end
      S_RW: begin
        bk       = {1'b0, a[addr_width_lp-1 -: bank_width_lp]};
        ad[9:0]  = col[9:0];
        ad[11]   = col[10]; // addr[10] stays 0: no autoprecharge
        enc      = we ? enc_wr_lp : enc_rd_lp;
      end
      default: ;
    endcase
    // cke=1, reset_n=1, odt=0 on every command
    return {bk, ad, 1'b1, enc, 1'b1, 1'b0};
  endfunction

  // Control state (async reset)
  state_e                   state_r, state_n;
  logic                     cmd_v_r, cmd_v_n;
  logic                     init_done_r, init_done_n;
  logic                     open_v_r, open_v_n;
  logic [id_width_lp-1:0]   rr_last_r, rr_last_n;
  logic [id_width_lp-1:0]   lat_id_r, lat_id_n;
  logic [2:0]               burst_r, burst_n;
  logic [2:0]               cas_r, cas_n;

  // Datapath state (no reset)
  logic [25:0]              cmd_data_r, cmd_data_n;
  logic                     lat_we_r, lat_we_n;
  logic [addr_width_lp-1:0] lat_addr_r, lat_addr_n;
  logic [1:0]               open_bank_r, open_bank_n;
  logic [row_width_p-1:0]   open_row_r, open_row_n;

  // Unpacked view of the per-client addresses
  logic [addr_width_lp-1:0] req_addr_a [num_req_p];

  for (genvar i = 0; i < num_req_p; i++) begin : g_unpack
    assign req_addr_a[i] = req_addr_i[i*addr_width_lp +: addr_width_lp];
  end

  // Round-robin pick: lowest requester above rr_last if any, else lowest
  // requester overall (the wrap-around case).
  logic                   found_hi, found_lo;
  logic [id_width_lp-1:0] pick_hi, pick_lo, grant_id;

  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (req_v_i[i] && !found_lo) begin
        found_lo = 1'b1;
        pick_lo  = id_width_lp'(i);
      end
      if (req_v_i[i] && !found_hi && (i > int'(rr_last_r))) begin
        found_hi = 1'b1;
        pick_hi  = id_width_lp'(i);
      end
    end
    grant_id = found_hi ? pick_hi : pick_lo;
  end

  logic                     fire;
  logic [addr_width_lp-1:0] grant_addr;
  logic [1:0]               grant_bank;
  logic [row_width_p-1:0]   grant_row;
  logic                     grant_miss;

  assign fire       = cmd_v_r & cmd_ready_i;
  assign grant_addr = req_addr_a[grant_id];
  assign grant_bank = grant_addr[addr_width_lp-1 -: bank_width_lp];
  assign grant_row  = grant_addr[col_width_lp +: row_width_p];
  // Only one row is tracked downstream, so any bank change is also a miss.
  assign grant_miss = !open_v_r || (grant_bank != open_bank_r) || (grant_row != open_row_r);

  // Next-state and output decode
  always_comb begin
    state_n     = state_r;
    init_done_n = init_done_r;
    open_v_n    = open_v_r;
    rr_last_n   = rr_last_r;
    lat_id_n    = lat_id_r;
    burst_n     = burst_r;
    cas_n       = cas_r;
    lat_we_n    = lat_we_r;
    lat_addr_n  = lat_addr_r;
    open_bank_n = open_bank_r;
    open_row_n  = open_row_r;
    req_ready_o = '0;
    cfg_ready_o = 1'b0;

    case (state_r)
      S_LMR: begin
        if (fire) begin
          init_done_n = 1'b1;
          open_v_n    = 1'b0;  // mode change closes the tracked row
          state_n     = S_IDLE;
        end
      end
      S_IDLE: begin
        if (cfg_v_i) begin
          cfg_ready_o = 1'b1;
          burst_n     = cfg_burst_len_i;
          cas_n       = cfg_cas_i;
          state_n     = S_LMR;
        end else if (|req_v_i) begin
          req_ready_o[grant_id] = 1'b1;
          lat_we_n   = req_we_i[grant_id];
          lat_addr_n = grant_addr;
          lat_id_n   = grant_id;
          rr_last_n  = grant_id;
          state_n    = grant_miss ? S_ACT : S_RW;
        end
      end
      S_ACT: begin
        if (fire) begin
          open_v_n    = 1'b1;
          open_bank_n = lat_addr_r[addr_width_lp-1 -: bank_width_lp];
          open_row_n  = lat_addr_r[col_width_lp +: row_width_p];
          state_n     = S_RW;
        end
      end
      S_RW: begin
        if (fire) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_LMR;
    endcase

    // The command register is loaded with what the next state presents, so
    // during a stall (state_n == state_r, latches unchanged) it reloads the
    // same word and stays stable.
    cmd_v_n    = (state_n != S_IDLE);
    cmd_data_n = build_cmd(state_n, lat_we_n, lat_addr_n, burst_n, cas_n);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= S_LMR;
      cmd_v_r     <= 1'b0;
      init_done_r <= 1'b0;
      open_v_r    <= 1'b0;
      rr_last_r   <= id_width_lp'(num_req_p - 1);
      lat_id_r    <= '0;
      burst_r     <= burst_len_code_p;
      cas_r       <= cas_code_p;
    end else begin
      state_r     <= state_n;
      cmd_v_r     <= cmd_v_n;
      init_done_r <= init_done_n;
      open_v_r    <= open_v_n;
      rr_last_r   <= rr_last_n;
      lat_id_r    <= lat_id_n;
      burst_r     <= burst_n;
      cas_r       <= cas_n;
    end
  end

  always_ff @(posedge clk_i) begin
    cmd_data_r  <= cmd_data_n;
    lat_we_r    <= lat_we_n;
    lat_addr_r  <= lat_addr_n;
    open_bank_r <= open_bank_n;
    open_row_r  <= open_row_n;
  end

  assign cmd_v_o      = cmd_v_r;
  assign cmd_data_o   = cmd_data_r;
  assign cmd_req_id_o = lat_id_r;
  assign init_done_o  = init_done_r;

endmodule

// File: tb/tb_bsg_dmc_cmd_sequencer.sv
module tb_bsg_dmc_cmd_sequencer;

  localparam int NREQ = 2;
  localparam int AW   = 27;

  logic            clk;
  logic            reset_n;
  logic [NREQ-1:0] req_v, req_we, req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic            cfg_v, cfg_ready;
  logic [2:0]      cfg_bl, cfg_cas;
  logic            cmd_v, cmd_ready, init_done;
  logic [25:0]     cmd_data;
  logic [0:0]      cmd_id;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [3:0] LMR = 4'b0000;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;

  bsg_dmc_cmd_sequencer dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .req_v_i         (req_v),
    .req_we_i        (req_we),
    .req_addr_i      (req_addr),
    .req_ready_o     (req_ready),
    .cfg_v_i         (cfg_v),
    .cfg_burst_len_i (cfg_bl),
    .cfg_cas_i       (cfg_cas),
    .cfg_ready_o     (cfg_ready),
    .cmd_v_o         (cmd_v),
    .cmd_data_o      (cmd_data),
    .cmd_ready_i     (cmd_ready),
    .cmd_req_id_o    (cmd_id),
    .init_done_o     (init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [25:0] cw(input logic [2:0] bk, input logic [15:0] ad,
                                     input logic [3:0] enc);
    return {bk, ad, 1'b1, enc, 1'b1, 1'b0};
  endfunction

  function automatic logic [AW-1:0] ra(input logic [1:0] b, input logic [13:0] r,
                                      input logic [10:0] c);
    return {b, r, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [25:0] held;

  initial begin
    reset_n   = 1'b0;
    req_v     = '0;
    req_we    = '0;
    req_addr  = '0;
    cfg_v     = 1'b0;
    cfg_bl    = 3'b000;
    cfg_cas   = 3'b000;
    cmd_ready = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_cmd_v",     32'(cmd_v),     32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);

    // 1: first command is LMR with reset mode
    reset_n = 1'b1;
    step();
    chk("lmr0_v",    32'(cmd_v),    32'd1);
    chk("lmr0_data", 32'(cmd_data), 32'(cw(3'b000, 16'h0033, LMR)));
    chk("lmr0_init", 32'(init_done), 32'd0);
    step();
    chk("init_done", 32'(init_done), 32'd1);
    chk("idle_v",    32'(cmd_v),     32'd0);

    // 2: WR to bank1 row 5 col 0x400 -> ACT then WR
    req_v    = 2'b01;
    req_we   = 2'b01;
    req_addr = {ra(2'd0, 14'h0, 11'h0), ra(2'd1, 14'h0005, 11'h400)};
    #1;
    chk("t2_ready", 32'(req_ready), 32'd1);
    step();
    req_v = 2'b00;
    chk("t2_act_v",    32'(cmd_v),     32'd1);
    chk("t2_act_data", 32'(cmd_data),  32'(cw(3'b001, 16'h0005, ACT)));
    chk("t2_busy_rdy", 32'(req_ready), 32'd0);
    step();
    chk("t2_wr_data", 32'(cmd_data), 32'(cw(3'b001, 16'h0800, WR)));
    chk("t2_wr_id",   32'(cmd_id),   32'd0);
    step();
    chk("t2_idle_v", 32'(cmd_v), 32'd0);

    // 3: RD same bank/row -> RD only
    req_v    = 2'b01;
    req_we   = 2'b00;
    req_addr = {ra(2'd1, 14'h0005, 11'h00B), ra(2'd1, 14'h0005, 11'h00A)};
    step();
    chk("t3_rd_v",    32'(cmd_v),    32'd1);
    chk("t3_rd_data", 32'(cmd_data), 32'(cw(3'b001, 16'h000A, RD)));
    chk("t3_rd_id",   32'(cmd_id),   32'd0);

    // 4: both clients valid -> grants alternate
    req_v = 2'b11;
    step();
    chk("t4_idle_v", 32'(cmd_v),     32'd0);
    chk("t4_rdy_a",  32'(req_ready), 32'd2);
    step();
    chk("t4_id_a",   32'(cmd_id),    32'd1);
    chk("t4_data_a", 32'(cmd_data),  32'(cw(3'b001, 16'h000B, RD)));
    step();
    chk("t4_rdy_b",  32'(req_ready), 32'd1);
    step();
    chk("t4_id_b",   32'(cmd_id),    32'd0);
    chk("t4_data_b", 32'(cmd_data),  32'(cw(3'b001, 16'h000A, RD)));
    step();
    chk("t4_rdy_c",  32'(req_ready), 32'd2);
    step();
    req_v = 2'b00;
    chk("t4_id_c",   32'(cmd_id),    32'd1);
    step();

    // 5: stall during ACT
    req_v    = 2'b01;
    req_we   = 2'b01;
    req_addr = {ra(2'd0, 14'h0, 11'h0), ra(2'd2, 14'h0123, 11'h005)};
    step();
    req_v     = 2'b00;
    cmd_ready = 1'b0;
    held      = cmd_data;
    chk("t5_act_data", 32'(cmd_data), 32'(cw(3'b010, 16'h0123, ACT)));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_stall_v",    32'(cmd_v),    32'd1);
      chk("t5_stall_data", 32'(cmd_data), 32'(cw(3'b010, 16'h0123, ACT)));
    end
    cmd_ready = 1'b1;
    step();
    chk("t5_wr_data", 32'(cmd_data), 32'(cw(3'b010, 16'h0005, WR)));
    chk("t5_wr_id",   32'(cmd_id),   32'd0);
    step();

    // 6: cfg and request in the same idle cycle -> LMR first, then ACT
    cfg_v    = 1'b1;
    cfg_bl   = 3'b100;
    cfg_cas  = 3'b011;
    req_v    = 2'b01;
    req_we   = 2'b00;
    req_addr = {ra(2'd0, 14'h0, 11'h0), ra(2'd2, 14'h0123, 11'h006)};
    #1;
    chk("t6_cfg_rdy", 32'(cfg_ready), 32'd1);
    chk("t6_req_rdy", 32'(req_ready), 32'd0);
    step();
    cfg_v = 1'b0;
    chk("t6_lmr_data", 32'(cmd_data),  32'(cw(3'b000, 16'h0034, LMR)));
    chk("t6_lmr_rdy",  32'(req_ready), 32'd0);
    step();
    chk("t6_idle_rdy", 32'(req_ready), 32'd1);
    chk("t6_init",     32'(init_done), 32'd1);
    step();
    req_v = 2'b00;
    chk("t6_act_data", 32'(cmd_data), 32'(cw(3'b010, 16'h0123, ACT)));
    step();
    cmd_ready = 1'b0;
    chk("t6_rd_data", 32'(cmd_data), 32'(cw(3'b010, 16'h0006, RD)));

    // 7: async reset during a stalled RD
    step();
    chk("t7_stall_v", 32'(cmd_v), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t7_async_v",    32'(cmd_v),     32'd0);
    chk("t7_async_init", 32'(init_done), 32'd0);
    step();
    cmd_ready = 1'b1;
    reset_n   = 1'b1;
    step();
    chk("t7_lmr_v",    32'(cmd_v),    32'd1);
    chk("t7_lmr_data", 32'(cmd_data), 32'(cw(3'b000, 16'h0033, LMR)));
    step();
    chk("t7_init", 32'(init_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
